uart_tx_unit: RTL
=================

Name: uart_tx_unit

Overview:
UART transmitter, the transmit-side counterpart of the team's RxUnit receiver. It accepts a byte on a one-cycle send strobe and serialises it onto data_tx. The frame is: start bit, 8 data bits LSB first, optional parity bit, stop bit. Baud rate and parity use the same 2-bit encodings as RxUnit, so one config register drives both ends.

Parameters:
CLK_FREQ  50_000_000  system clock frequency in Hz; bit divisors are computed from it at elaboration.

Ports:
clock        input   1  system clock; all logic is on the rising edge.
reset_n      input   1  asynchronous active-low reset.
send         input   1  transmit request; sampled only when the unit is idle.
data_in      input   8  byte to transmit; latched when send is accepted.
parity_type  input   2  00 = none, 01 = odd, 10 = even, 11 = none.
baud_rate    input   2  00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
data_tx      output  1  serial line; idles high.
active_flag  output  1  high while a frame is in progress.
done_flag    output  1  one-cycle pulse when a frame completes.

Behaviour:
- Divisor: DIV = CLK_FREQ / baud, integer truncation. Defaults give 20833, 10416, 5208 and 2604 for codes 00, 01, 10 and 11.
- Every bit lasts exactly DIV clock cycles.
- Reset (asynchronous assert): data_tx=1, active_flag=0, done_flag=0, FSM=IDLE, baud counter=0, bit index=0, latched byte/config=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - data_tx=1, active_flag=0.
  - If send=1 at edge k: latch data_in, parity_type and baud_rate; go to START.
  - From edge k: data_tx=0 and active_flag=1 (one-cycle latency from the send edge).
- START: drive 0 for DIV cycles, then go to DATA with bit index 0.
- DATA:
  - Drive latched bit[index] for DIV cycles per bit.
  - After bit 7: go to PARITY if latched parity_type is 01 or 10, else go to STOP.
- PARITY:
  - Odd: bit = ~^byte. Even: bit = ^byte.
  - Drive it for DIV cycles, then go to STOP.
- STOP: drive 1 for DIV cycles; on the last cycle, go to IDLE.
- done_flag: registered; high for exactly the first cycle after re-entering IDLE. active_flag is 0 in that cycle.
- Frame length: 11 bits with parity, 10 bits without.
- send while active_flag=1 is ignored; it is not queued. data_in changes mid-frame have no effect.
- send in the same cycle as done_flag=1 is accepted. Minimum inter-frame gap is 1 idle clock cycle with data_tx=1.
- Changes to baud_rate or parity_type mid-frame have no effect; the values latched at accept are used until the frame ends.
- Reset asserted mid-frame: data_tx returns to 1 immediately (asynchronous) and the frame is abandoned. No done_flag is produced. After release, the unit waits in IDLE for a fresh send.
- Baud counter: counts 0..DIV-1 and reloads to 0 at each bit boundary. Width ≥ 15 bits for the defaults, sized from the maximum divisor.
- No glitches on data_tx: it is driven from a register.

Test Plan:
1. Reset held 50 ns, then released with no send -> data_tx=1, active_flag=0, done_flag=0 for 10 µs.
2. baud_rate=10, parity_type=01, data_in=0x95, send pulse -> data_tx sequence 0,1,0,1,0,1,0,0,1,1(parity),1(stop). Each bit lasts 5208 clocks. Then done_flag=1 for one cycle, 11*5208 cycles after the cycle following send.
3. baud_rate=11, parity_type=10, data_in=0xCC -> sequence 0,0,0,1,1,0,0,1,1,0(parity),1 with 2604 clocks per bit. Loopback into RxUnit yields data_out=0xCC and error_flag=000.
4. parity_type=00, data_in=0xA5, baud_rate=00 -> 10-bit frame 0,1,0,1,0,0,1,0,1,1 with 20833 clocks per bit and no parity bit.
5. send=1 held continuously with data_in changing mid-frame 0x3C→0xFF -> first frame carries 0x3C. Second frame (0xFF) starts exactly 1 cycle after done_flag. Mid-frame send requests are ignored.
6. Reset asserted during data bit 3 -> data_tx=1 and active_flag=0 asynchronously, with no done_flag. A new send of 0x55 after release transmits a correct full frame.

Source files
------------

// File: rtl/uart_tx_unit.sv
// ---------------------------------------------------------------------------
// uart_tx_unit
// UART transmitter. On an accepted send it sends one frame on data_tx:
// a start bit, 8 data bits LSB first, an optional parity bit and a stop bit.
// The baud-rate and parity codes match the receiver, so one config register
// can drive both ends.
//
// Ports:
//   clock        system clock, rising-edge logic
//   reset_n      asynchronous active-low reset
//   send         transmit request, sampled only while idle
//   data_in      byte to transmit, latched on accept
//   parity_type  00 none, 01 odd, 10 even, 11 none
//   baud_rate    00 2400, 01 4800, 10 9600, 11 19200 baud
//   data_tx      serial line (idles high, driven from a register)
//   active_flag  high while a frame is in progress
//   done_flag    one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx_unit #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  // The counter only holds values up to DIV-1, so log2 of the slowest
  // divisor gives enough bits.
  localparam int DIV_MAX = CLK_FREQ / 2400;
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_2400  = CNT_W'(CLK_FREQ / 2400);
  localparam logic [CNT_W-1:0] DIV_4800  = CNT_W'(CLK_FREQ / 4800);
  localparam logic [CNT_W-1:0] DIV_9600  = CNT_W'(CLK_FREQ / 9600);
  localparam logic [CNT_W-1:0] DIV_19200 = CNT_W'(CLK_FREQ / 19200);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [7:0]       byte_r, byte_nxt_s;
  logic [1:0]       par_r, par_nxt_s;
  logic [1:0]       baud_r, baud_nxt_s;
  logic [CNT_W-1:0] div_s;
  logic             bit_last_s;
  logic             par_bit_s;
  logic             tx_nxt_s;
  logic             active_nxt_s;
  logic             done_nxt_s;

  function automatic logic [CNT_W-1:0] div_sel(input logic [1:0] code);
    logic [CNT_W-1:0] d;
    case (code)
      2'b00:   d = DIV_2400;
      2'b01:   d = DIV_4800;
      2'b10:   d = DIV_9600;
      2'b11:   d = DIV_19200;
      default: d = DIV_19200;
    endcase
    return d;
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] code);
    logic p;
    case (code)
      2'b01:   p = ~^d;
      2'b10:   p = ^d;
      default: p = 1'b1;
    endcase
    return p;
  endfunction

  function automatic logic has_parity(input logic [1:0] code);
    return (code == 2'b01) || (code == 2'b10);
  endfunction

  assign div_s      = div_sel(baud_r);
  assign bit_last_s = (cnt_r == (div_s - CNT_W'(1)));

  // State, counters and latched frame parameters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      byte_r  <= 8'd0;
      par_r   <= 2'd0;
      baud_r  <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      byte_r  <= byte_nxt_s;
      par_r   <= par_nxt_s;
      baud_r  <= baud_nxt_s;
    end
  end

  // Next-state logic: each non-idle state holds for DIV cycles.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    byte_nxt_s  = byte_r;
    par_nxt_s   = par_r;
    baud_nxt_s  = baud_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
        idx_nxt_s = 3'd0;
        if (send) begin
          state_nxt_s = START;
          byte_nxt_s  = data_in;
          par_nxt_s   = parity_type;
          baud_nxt_s  = baud_rate;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_last_s) begin
          state_nxt_s = DATA;
          cnt_nxt_s   = '0;
          idx_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_last_s) begin
          cnt_nxt_s = '0;
          if (idx_r == 3'd7) begin
            idx_nxt_s   = 3'd0;
            state_nxt_s = has_parity(par_r) ? PARITY : STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_last_s) begin
          state_nxt_s = STOP;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_last_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe (line goes low on the accepting edge).
  always_comb begin
    par_bit_s    = parity_bit(byte_nxt_s, par_nxt_s);
    tx_nxt_s     = 1'b1;
    active_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s   = (state_r == STOP) && (state_nxt_s == IDLE);
    case (state_nxt_s)
      IDLE:    tx_nxt_s = 1'b1;
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = byte_nxt_s[idx_nxt_s];
      PARITY:  tx_nxt_s = par_bit_s;
      STOP:    tx_nxt_s = 1'b1;
      default: tx_nxt_s = 1'b1;
    endcase
  end

  // Output registers; reset forces the line high immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      data_tx     <= tx_nxt_s;
      active_flag <= active_nxt_s;
      done_flag   <= done_nxt_s;
    end
  end

endmodule
